// File: rtl/rgmii_rx_pkg.sv
// Shared constants and types for the RGMII receive decoder.
//   SFD / PREAMBLE         : framing bytes recognised by the decoder FSM
//   FALSE_CARRIER / CARRIER_EXT : non-data codes carried on RXD when dv=0, er=1
//   link_speed_e           : in-band speed encoding
//   rx_state_e             : framing FSM states
//   inband_status_t        : layout of the in-band status nibble
package rgmii_rx_pkg;

    localparam logic [7:0] SFD      = 8'hD5;
    localparam logic [7:0] PREAMBLE = 8'h55;

    localparam logic [3:0] FALSE_CARRIER = 4'hE;
    localparam logic [3:0] CARRIER_EXT   = 4'hF;

    typedef enum logic [1:0] {
        SPEED_10      = 2'b00,
        SPEED_100     = 2'b01,
        SPEED_1000    = 2'b10,
        SPEED_INVALID = 2'b11
    } link_speed_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } rx_state_e;

    // Packed MSB-first so a raw RXD nibble casts straight onto the fields.
    typedef struct packed {
        logic        duplex;  // bit 3
        link_speed_e speed;   // bits 2:1
        logic        link;    // bit 0
    } inband_status_t;

endpackage

// File: rtl/rgmii_rx_decode_if.sv
// GMII-side receive stream produced by rgmii_rx_decode.
//   gmii_rxd     : received byte
//   gmii_rx_dv   : data valid
//   gmii_rx_er   : receive error
//   gmii_rx_ce   : byte strobe; the three signals above are meaningful only when high
//   frame_start  : pulse on the strobe carrying the SFD
//   frame_end    : pulse on the first strobe after dv drops inside a frame
// master = decoder side, slave = MAC side.
interface rgmii_rx_decode_if;

    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_rx_ce;
    logic       frame_start;
    logic       frame_end;

    modport master (
        output gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_ce, frame_start, frame_end
    );

    modport slave (
        input  gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_ce, frame_start, frame_end
    );

endinterface

// File: rtl/rgmii_inband_status.sv
// In-band link status filter for the RGMII receive path.
// Samples RXD while the line is idle (dv=0, er=0, both edges equal) and only
// updates the link outputs once STATUS_FILTER consecutive identical samples
// have been seen. Speed code 11 never updates the outputs.
//   clk, rst_n     : receive clock, async active-low reset
//   dv, er         : decoded RX_DV / RX_ER for this cycle
//   rx_d1, rx_d2   : rising / falling edge RXD samples
//   link_up, link_speed, link_duplex : filtered status
module rgmii_inband_status
    import rgmii_rx_pkg::*;
#(
    parameter int unsigned STATUS_FILTER = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dv,
    input  logic       er,
    input  logic [3:0] rx_d1,
    input  logic [3:0] rx_d2,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
);

    localparam int unsigned FILT_N = (STATUS_FILTER < 1) ? 1 : STATUS_FILTER;
    localparam int unsigned CW     = $clog2(FILT_N + 1);
    localparam logic [CW-1:0] FILT = CW'(FILT_N);

    inband_status_t smp;
    logic [3:0]     cand;
    logic [CW-1:0]  run;
    logic [CW-1:0]  run_nxt;
    logic           sample_ok;

    assign smp = inband_status_t'(rx_d1);

    // Anything other than a valid idle sample (dv cycle, error code,
    // unequal edges) restarts the run; a new value starts a run of one.
    always_comb begin
        sample_ok = !dv && !er && (rx_d1 == rx_d2);
        run_nxt   = '0;
        if (sample_ok) begin
            if (run != '0 && rx_d1 == cand) begin
                run_nxt = (run == FILT) ? run : run + 1'b1;
            end else begin
                run_nxt = CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand        <= '0;
            run         <= '0;
            link_up     <= 1'b0;
            link_speed  <= '0;
            link_duplex <= 1'b0;
        end else begin
            run <= run_nxt;
            if (sample_ok) begin
                cand <= rx_d1;
            end
            if (sample_ok && run_nxt == FILT && smp.speed != SPEED_INVALID) begin
                link_up     <= smp.link;
                link_speed  <= smp.speed;
                link_duplex <= smp.duplex;
            end
        end
    end

endmodule

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: turns the q1/q2 samples of the DDR input stage into
// a byte-wide GMII stream, tracks preamble/SFD framing, decodes in-band link
// status and keeps saturating frame/error counters.
//   clk, rst_n        : receive clock, async active-low reset
//   rx_d1, rx_d2      : RXD rising / falling edge samples
//   rx_ctl1, rx_ctl2  : RX_CTL rising (RX_DV) / falling (RX_DV ^ RX_ER) samples
//   mii_select        : 1 = 10/100 nibble mode, 0 = 1000 byte mode (latched in idle)
//   gmii              : GMII stream, strobe and frame pulses (master modport)
//   link_up, link_speed, link_duplex : filtered in-band status
//   frame_count, err_count           : saturating counters
module rgmii_rx_decode
    import rgmii_rx_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned STATUS_FILTER = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           rx_d1,
    input  logic [3:0]           rx_d2,
    input  logic                 rx_ctl1,
    input  logic                 rx_ctl2,
    input  logic                 mii_select,
    rgmii_rx_decode_if.master    gmii,
    output logic                 link_up,
    output logic [1:0]           link_speed,
    output logic                 link_duplex,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] err_count
);

    logic dv;
    logic er;
    assign dv = rx_ctl1;
    assign er = rx_ctl1 ^ rx_ctl2;

    rx_state_e  state;
    rx_state_e  state_nxt;
    logic       mii_mode;
    logic       phase;
    logic [3:0] low_nib;
    logic       low_er;
    logic       armed;
    logic       err_seen;
    logic       fc_prev;

    // Byte event assembly. In nibble mode an idle cycle (dv=0, no low nibble
    // pending) is itself a byte event so dv=0 and non-data codes reach the
    // FSM and the output every cycle while the line is idle.
    logic       ev;
    logic [7:0] bbyte;
    logic       bdv;
    logic       ber;
    logic       dribble;

    always_comb begin
        ev      = 1'b0;
        bbyte   = '0;
        bdv     = 1'b0;
        ber     = 1'b0;
        dribble = 1'b0;
        if (!mii_mode) begin
            ev    = 1'b1;
            bbyte = {rx_d2, rx_d1};
            bdv   = dv;
            ber   = er;
        end else if (dv) begin
            if (phase) begin
                ev    = 1'b1;
                bbyte = {rx_d1, low_nib};
                bdv   = 1'b1;
                ber   = er | low_er;
            end
        end else if (phase) begin
            ev      = 1'b1;
            bbyte   = {4'h0, low_nib};
            bdv     = 1'b1;
            ber     = 1'b1;
            dribble = 1'b1;
        end else begin
            ev    = 1'b1;
            bbyte = {4'h0, rx_d1};
            bdv   = 1'b0;
            ber   = er;
        end
    end

    logic fs;
    logic fe;
    logic fsm_err;

    always_comb begin
        state_nxt = state;
        fs        = 1'b0;
        fe        = 1'b0;
        fsm_err   = 1'b0;
        if (ev) begin
            case (state)
                IDLE: begin
                    // armed blocks entry into a frame already running at reset release
                    if (bdv && armed) state_nxt = PRE;
                end
                PRE: begin
                    if (!bdv) begin
                        state_nxt = IDLE;
                        fsm_err   = 1'b1;
                    end else if (ber || (bbyte != SFD && bbyte != PREAMBLE)) begin
                        state_nxt = DROP;
                        fsm_err   = 1'b1;
                    end else if (bbyte == SFD) begin
                        state_nxt = DATA;
                        fs        = 1'b1;
                    end
                end
                DATA: begin
                    if (!bdv) begin
                        state_nxt = IDLE;
                        fe        = 1'b1;
                    end else if (ber && !err_seen) begin
                        fsm_err = 1'b1;
                    end
                end
                DROP: begin
                    if (!bdv) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    logic fwd;
    logic code_er;
    logic fc_now;

    assign fwd     = (state_nxt == PRE) || (state_nxt == DATA);
    assign code_er = ber && (rx_d1 == FALSE_CARRIER || rx_d1 == CARRIER_EXT);
    assign fc_now  = ev && !bdv && ber && (rx_d1 == FALSE_CARRIER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            mii_mode         <= 1'b0;
            phase            <= 1'b0;
            low_nib          <= '0;
            low_er           <= 1'b0;
            armed            <= 1'b0;
            err_seen         <= 1'b0;
            fc_prev          <= 1'b0;
            gmii.gmii_rxd    <= '0;
            gmii.gmii_rx_dv  <= 1'b0;
            gmii.gmii_rx_er  <= 1'b0;
            gmii.gmii_rx_ce  <= 1'b0;
            gmii.frame_start <= 1'b0;
            gmii.frame_end   <= 1'b0;
            frame_count      <= '0;
            err_count        <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && !dv) mii_mode <= mii_select;

            if (!dv) begin
                armed <= 1'b1;
            end else if (state == IDLE && state_nxt == PRE) begin
                armed <= 1'b0;
            end

            phase <= mii_mode && dv && !phase;
            if (mii_mode && dv && !phase) begin
                low_nib <= rx_d1;
                low_er  <= er;
            end

            if (fs) begin
                err_seen <= 1'b0;
            end else if (state == DATA && ev && bdv && ber) begin
                err_seen <= 1'b1;
            end

            fc_prev <= fc_now;

            gmii.gmii_rx_ce  <= ev;
            gmii.frame_start <= fs;
            gmii.frame_end   <= fe;
            if (ev) begin
                gmii.gmii_rxd   <= bbyte;
                gmii.gmii_rx_dv <= bdv && fwd;
                gmii.gmii_rx_er <= bdv ? (ber && fwd) : code_er;
            end

            if (fe && frame_count != '1) frame_count <= frame_count + 1'b1;

            // Sources can coincide (a dribble byte is also an er byte); one count per cycle.
            if ((fsm_err || dribble || (fc_now && !fc_prev)) && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    rgmii_inband_status #(
        .STATUS_FILTER (STATUS_FILTER)
    ) u_status (
        .clk         (clk),
        .rst_n       (rst_n),
        .dv          (dv),
        .er          (er),
        .rx_d1       (rx_d1),
        .rx_d2       (rx_d2),
        .link_up     (link_up),
        .link_speed  (link_speed),
        .link_duplex (link_duplex)
    );

endmodule
